xor_stream_checksum: RTL and testbench

- Parametrised, clocked successor to the two-input XOR gate.
- Folds a stream of WIDTH-bit words into a running bitwise-XOR checksum over a frame delimited by in_last.
- Generate mode: emits the checksum and an overall parity bit.
- Check mode: the frame's final word is a check word, and the block flags a mismatch.
- Sits on the team's datapath between a word source and a result consumer, using valid/ready handshakes on both sides.

---
 rtl/xor_stream_checksum.sv | 107 ++++++++++
 tb/tb_xor_stream_checksum.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_checksum.sv
// Streaming XOR checksum: folds a frame of words into a running XOR, then
// presents sum/parity/error/overflow/length until the consumer takes it.
module xor_stream_checksum #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic             out_err,
  output logic             out_ovf,
  output logic [CW-1:0]    out_len
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             parity;
    logic             err;
    logic             ovf;
    logic [CW-1:0]    len;
  } res_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mode_q, mode_d;
  res_t             res_q, res_d;

  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    count_inc;
  logic             frame_mode;

  assign acc_nxt    = acc_q ^ in_data;
  assign count_inc  = count_q + CW'(1);
  // The first beat's mode governs the frame, even when it also closes it.
  assign frame_mode = (count_q == '0) ? mode : mode_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    res_d   = res_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          mode_d = frame_mode;
          if (in_last || count_inc == MAX_CNT) begin
            res_d.sum    = acc_nxt;
            res_d.parity = ^acc_nxt;
            res_d.err    = frame_mode & (|acc_nxt);
            res_d.ovf    = ~in_last;
            res_d.len    = count_inc;
            acc_d        = '0;
            count_d      = '0;
            state_d      = HOLD;
          end else begin
            acc_d   = acc_nxt;
            count_d = count_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_sum    = res_q.sum;
  assign out_parity = res_q.parity;
  assign out_err    = res_q.err;
  assign out_ovf    = res_q.ovf;
  assign out_len    = res_q.len;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Directed + randomized bench for xor_stream_checksum; expected results come
// from a queue-based frame model built from the block's framing rules.
module tb_xor_stream_checksum;
  localparam int W  = 8;
  localparam int ML = 16;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_parity;
  logic          out_err;
  logic          out_ovf;
  logic [CW-1:0] out_len;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic         fmode;
  bit           closed;

  xor_stream_checksum #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_parity(out_parity), .out_err(out_err), .out_ovf(out_ovf), .out_len(out_len)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, then check against the model.
  task automatic send(input logic [W-1:0] d, input logic l, input logic m);
    int n = 0;
    logic [W-1:0] s;
    in_valid = 1'b1; in_data = d; in_last = l; mode = m;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_wait", in_ready, 1);
    if (q.size() == 0) fmode = m;
    q.push_back(d);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = W'($urandom); mode = 1'($urandom);
    closed = l || (q.size() == ML);
    if (closed) begin
      s = '0;
      foreach (q[i]) s ^= q[i];
      chk("valid", out_valid, 1);
      chk("sum", out_sum, s);
      chk("parity", out_parity, $countones(s) % 2);
      chk("err", out_err, (fmode && s != 0) ? 1 : 0);
      chk("ovf", out_ovf, l ? 0 : 1);
      chk("len", out_len, q.size());
      q.delete();
    end else begin
      chk("busy", out_valid, 0);
    end
  endtask

  task automatic ack(input int delay);
    repeat (delay) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_inrdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ack_valid", out_valid, 0);
    chk("ack_inrdy", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] hs;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_inrdy", in_ready, 1);
    chk("rst_sum", out_sum, 0);
    chk("rst_len", out_len, 0);
    chk("rst_flags", {out_parity, out_err, out_ovf}, 0);
    rst = 1'b0;

    // generate frame
    send(8'h0F, 0, 0); send(8'hF0, 0, 0); send(8'h3C, 1, 0);
    chk("t1_sum", out_sum, 8'hC3);
    chk("t1_len", out_len, 3);
    chk("t1_par", out_parity, 0);
    ack(0);

    // check mode, good then bad check word
    send(8'hA5, 0, 1); send(8'h5A, 0, 1); send(8'hFF, 1, 1);
    chk("t2_sum", out_sum, 8'h00);
    chk("t2_err", out_err, 0);
    ack(1);
    send(8'hA5, 0, 1); send(8'h5A, 0, 1); send(8'hFE, 1, 1);
    chk("t2b_sum", out_sum, 8'h01);
    chk("t2b_err", out_err, 1);
    chk("t2b_par", out_parity, 1);
    ack(0);

    // overflow at MAX_LEN, then the 17th beat opens a new frame
    for (int i = 0; i < ML; i++) send(8'h01, 0, 0);
    chk("t3_ovf", out_ovf, 1);
    chk("t3_len", out_len, ML);
    chk("t3_sum", out_sum, 8'h00);
    ack(0);
    send(8'h01, 1, 0);
    chk("t3b_len", out_len, 1);
    chk("t3b_sum", out_sum, 8'h01);
    ack(0);

    // backpressure: pending beat must wait for the handshake
    send(8'h5C, 1, 0);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; mode = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 8'h5C);
      chk("bp_len", out_len, 1);
      chk("bp_inrdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drop", out_valid, 0);
    chk("bp_inrdy1", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_sum", out_sum, 8'h77);
    chk("bp_next_len", out_len, 1);
    ack(0);

    // single beat, then mode toggled mid-frame
    send(8'h80, 1, 0);
    chk("t5_sum", out_sum, 8'h80);
    chk("t5_par", out_parity, 1);
    chk("t5_len", out_len, 1);
    ack(0);
    send(8'hA5, 0, 1); send(8'h5A, 0, 0); send(8'hFE, 1, 0);
    chk("t5_chk_err", out_err, 1);
    ack(0);
    send(8'h01, 0, 0); send(8'h02, 0, 1); send(8'h04, 1, 1);
    chk("t5_gen_err", out_err, 0);
    chk("t5_gen_sum", out_sum, 8'h07);
    ack(0);

    // reset mid-frame discards accumulation
    send(8'h33, 0, 0); send(8'h44, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    repeat (2) begin
      chk("t6_valid", out_valid, 0);
      chk("t6_inrdy", in_ready, 1);
      tick();
    end
    send(8'h11, 1, 0);
    chk("t6_sum", out_sum, 8'h11);
    chk("t6_len", out_len, 1);
    ack(0);

    // randomized frames with gaps, random modes and random consumer delay
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(W'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
      if (closed) ack($urandom_range(0, 3));
    end
    if (q.size() != 0) begin
      send(W'($urandom), 1, 0);
      ack(0);
    end

    // reset while a result is held
    send(8'h09, 1, 0);
    hs = out_sum;
    chk("t7_held", hs, 8'h09);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t7_valid", out_valid, 0);
    chk("t7_sum", out_sum, 0);
    chk("t7_len", out_len, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
